// File: rtl/alu_serial_exec.sv
// Multi-cycle ALU execution responder: single-cycle add/sub/logic ops,
// bit-serial shifts (one position per cycle), valid/ready on both sides.
module alu_serial_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_in1,
  input  logic [WIDTH-1:0] req_in2,
  input  logic [2:0]       req_sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_out1,
  output logic             res_out2,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [2:0]       sel;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;

  assign shamt = req_in2[SHW-1:0];

  // Single-cycle result from the request inputs, registered on acceptance
  always_comb begin
    sum      = {1'b0, req_in1} + {1'b0, req_in2};
    diff     = {1'b0, req_in1} + {1'b0, ~req_in2} + {{WIDTH{1'b0}}, 1'b1};
    alu_res  = '0;
    alu_flag = 1'b0;
    case (req_sel)
      3'd0: begin
        alu_res  = sum[WIDTH-1:0];
        alu_flag = sum[WIDTH];
      end
      3'd1: begin
        alu_res  = diff[WIDTH-1:0];
        alu_flag = ~diff[WIDTH];
      end
      3'd2: begin
        alu_res  = req_in1 ^ req_in2;
        alu_flag = ((req_in1 ^ req_in2) == '0);
      end
      3'd3: begin
        alu_res  = req_in1 | req_in2;
        alu_flag = ((req_in1 | req_in2) == '0);
      end
      3'd4: begin
        alu_res  = req_in1 & req_in2;
        alu_flag = ((req_in1 & req_in2) == '0);
      end
      default: begin
        // zero-distance shift passes operand 1 through
        alu_res  = req_in1;
        alu_flag = (req_in1 == '0);
      end
    endcase
  end

  // One-bit step of the serial shifter
  always_comb begin
    shifted = work;
    case (sel)
      3'd5:    shifted = {work[WIDTH-2:0], 1'b0};
      3'd6:    shifted = {1'b0, work[WIDTH-1:1]};
      3'd7:    shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = work;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      sel       <= 3'd0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      res_out1  <= '0;
      res_out2  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel       <= req_sel;
            work      <= req_in1;
            cnt       <= shamt;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if ((req_sel >= 3'd5) && (shamt != '0)) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              res_out1  <= alu_res;
              res_out2  <= alu_flag;
              res_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state     <= DONE;
            res_out1  <= shifted;
            res_out2  <= (shifted == '0);
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_serial_exec.md
Name: alu_serial_exec

Overview:
- Multi-cycle execution responder for the NPC datapath.
- Accepts an ALU operation request (two operands plus 3-bit op select) over a valid/ready handshake.
- Computes add/sub/xor/or/and in one cycle. Computes shifts iteratively, one bit position per cycle.
- Returns the result and a flag over a second valid/ready handshake. Sits between decode/issue and writeback, for area-constrained configurations with no barrel shifter.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of two, ≥2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_in1  input  WIDTH  operand 1.
- req_in2  input  WIDTH  operand 2; for shifts only bits [SHW-1:0] are used as the shift amount.
- req_sel  input  3  op select: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts result.
- res_out1  output  WIDTH  result.
- res_out2  output  1  flag: add = carry-out; sub = borrow (in1 < in2 unsigned); ops 2–7 = result is zero.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - rst is asynchronous and active-high.
  - Asserting rst forces state=IDLE, req_ready=1, res_valid=0, res_out1=0, res_out2=0, busy=0, and the internal counter and operand registers to 0.
  - Reset mid-operation discards the in-flight op; no result is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready=1.
  - A request is accepted on a rising edge with req_valid & req_ready. Operands, sel and shamt=req_in2[SHW-1:0] are registered.
  - sel 0–4: result and flag computed from the registered inputs → DONE. res_valid is high in the cycle after acceptance (latency 1).
  - sel 5–7 with shamt=0: result = in1, flag = (in1==0) → DONE (latency 1).
  - sel 5–7 with shamt>0: → SHIFT; working register = in1, counter = shamt.
- SHIFT:
  - req_ready=0.
  - Each cycle the working register shifts by one bit:
    - sll: shift left, fill 0.
    - srl: shift right, fill 0.
    - sra: shift right, fill the MSB.
  - Counter decrements each cycle. When the counter reaches 1 the final shift occurs and the state → DONE.
  - Shift latency = shamt + 1 cycles from acceptance to res_valid. Maximum is WIDTH cycles (shamt = WIDTH-1).
- DONE:
  - res_valid=1. res_out1/res_out2 are held stable until res_valid & res_ready, then → IDLE.
  - If res_ready is already high on the first DONE cycle, the handshake completes that cycle.
  - req_ready=0 in DONE. A new request cannot be accepted in the same cycle the result is consumed; the next acceptance is the cycle after, in IDLE.
- Result registers are updated only on acceptance completion (DONE entry). They keep their value after consumption until the next result.
- Arithmetic rules:
  - add/sub are computed modulo 2^WIDTH.
  - Carry is bit WIDTH of the (WIDTH+1)-bit zero-extended sum.
  - Borrow = ~carry of in1 + ~in2 + 1.
  - Upper bits of req_in2 beyond SHW are ignored for shifts.
- Boundary conditions:
  - req_valid deasserted while not ready: no effect.
  - Request inputs changing while busy: ignored.
  - req_valid and res_ready both high in DONE: only the result handshake occurs.
  - X on req_sel while req_valid=0: must not affect state.

Test Plan:
- Reset, then add, WIDTH=32: in1=0xFFFFFFFF, in2=0x00000001, sel=0, res_ready=1.
  - Expect res_valid exactly 1 cycle after acceptance, res_out1=0x00000000, res_out2=1, then req_ready=1 the following cycle.
- Sub borrow: in1=3, in2=5, sel=1.
  - Expect res_out1=0xFFFFFFFE, res_out2=1.
- Sub no borrow: in1=5, in2=3.
  - Expect res_out1=2, res_out2=0.
- Logic ops: in1=0xF0F0F0F0, in2=0x0F0F0F0F.
  - xor → 0xFFFFFFFF, out2=0.
  - and → 0x00000000, out2=1.
  - or → 0xFFFFFFFF.
  - Each with latency 1.
- Shifts:
  - sra in1=0x80000000, in2=0x0000001F → res_out1=0xFFFFFFFF, res_valid 32 cycles after acceptance, busy high throughout, req_ready=0.
  - srl same operands → 0x00000001.
  - sll in1=1, in2=0x00000104 (shamt=4) → 0x00000010, latency 5.
  - shamt=0 → in1 unchanged, latency 1.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid.
  - Expect res_out1/res_out2/res_valid stable, req_ready=0, and a req_valid pulse ignored.
  - Release res_ready → IDLE next cycle.
- Reset mid-shift: sll with shamt=20, assert rst asynchronously (mid-cycle) at cycle 7.
  - Expect immediate res_valid=0, busy=0, res_out1=0, req_ready=1.
  - No result is ever emitted for the aborted op; a subsequent add 2+2 returns 4.
